// File: rtl/main_memory_ctrl.sv
// Backing-store controller behind data_cache. Block reads come back as a
// critical-word-first burst, and single-word writes get a one-beat ack.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | access latency countdown
// BURST | read beats streaming out
// ACK   | write acknowledge beat
module main_memory_ctrl #(
  parameter int ADDR_WIDTH      = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int DEPTH_WORDS     = 1024,
  parameter int LATENCY         = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic                  resp_last,
  output logic                  busy
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int OW = $clog2(WORDS_PER_BLOCK);
  localparam int BW = OW + 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, ACK} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            write_q, write_d;
  logic [31:0]     wdata_q, wdata_d;

  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_last_q, resp_last_d;
  logic [31:0]     resp_data_q, resp_data_d;

  logic [31:0]     mem_q [DEPTH_WORDS];
  logic            mem_we;
  logic [OW-1:0]   beat_sel;
  logic [IW-1:0]   rd_idx;

  logic unused_addr;
  assign unused_addr = ^{req_addr[ADDR_WIDTH-1:IW+2], req_addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      beat_q       <= '0;
      idx_q        <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      beat_q       <= beat_d;
      idx_q        <= idx_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_last_q  <= resp_last_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Contents survive reset; an aborted write never reaches the array.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    write_d = write_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = WAIT;
          cnt_d   = CW'(LATENCY - 1);
          beat_d  = '0;
          idx_d   = req_addr[IW+1:2];
          write_d = req_write;
          wdata_d = req_wdata;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = write_q ? ACK : BURST;
          beat_d  = write_q ? '0 : BW'(1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      BURST: begin
        if (beat_q == BW'(WORDS_PER_BLOCK)) begin
          state_d = IDLE;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // beat_q counts beats already sent, so it is also the offset of the next one.
  assign beat_sel = (state_q == WAIT) ? '0 : beat_q[OW-1:0];
  assign rd_idx   = {idx_q[IW-1:OW], idx_q[OW-1:0] + beat_sel};

  always_comb begin
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_last_d  = 1'b0;
    resp_data_d  = '0;
    mem_we       = 1'b0;
    case (state_q)
      IDLE: req_ready_d = !req_valid;
      WAIT: begin
        if (cnt_q == '0) begin
          resp_valid_d = 1'b1;
          if (write_q) begin
            mem_we      = 1'b1;
            resp_last_d = 1'b1;
          end else begin
            resp_data_d = mem_q[rd_idx];
          end
        end
      end
      BURST: begin
        if (beat_q == BW'(WORDS_PER_BLOCK)) begin
          req_ready_d = 1'b1;
        end else begin
          resp_valid_d = 1'b1;
          resp_data_d  = mem_q[rd_idx];
          resp_last_d  = (beat_q == BW'(WORDS_PER_BLOCK - 1));
        end
      end
      ACK:     req_ready_d = 1'b1;
      default: req_ready_d = 1'b0;
    endcase
  end

  assign req_ready  = req_ready_q;
  assign busy       = !req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_last  = resp_last_q;
  assign resp_data  = resp_data_q;

endmodule
